// File: rtl/noc_tx_arbiter_if.sv
// noc_tx_arbiter_if: flit handshake bundle between the three TX queues, the arbiter and the interdevice controller
interface noc_tx_arbiter_if #(parameter int FLIT_W = 128);
  logic [FLIT_W-1:0] ack_flit;
  logic              ack_flit_valid;
  logic              ack_flit_ready;
  logic [FLIT_W-1:0] wack_flit;
  logic              wack_flit_valid;
  logic              wack_flit_last;
  logic              wack_flit_ready;
  logic [FLIT_W-1:0] fwd_flit;
  logic              fwd_flit_valid;
  logic              fwd_flit_last;
  logic              fwd_flit_ready;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_out_valid;
  logic              flit_out_ready;
  modport slave (
    input  ack_flit, ack_flit_valid, wack_flit, wack_flit_valid, wack_flit_last,
    input  fwd_flit, fwd_flit_valid, fwd_flit_last, flit_out_ready,
    output ack_flit_ready, wack_flit_ready, fwd_flit_ready, flit_out, flit_out_valid
  );
  modport master (
    output ack_flit, ack_flit_valid, wack_flit, wack_flit_valid, wack_flit_last,
    output fwd_flit, fwd_flit_valid, fwd_flit_last, flit_out_ready,
    input  ack_flit_ready, wack_flit_ready, fwd_flit_ready, flit_out, flit_out_valid
  );
endinterface

// File: rtl/noc_tx_arbiter.sv
// noc_tx_arbiter: packet-locked arbiter sharing the TX channel among ack, retransmit and forward queues
module noc_tx_arbiter #(
  parameter int FLIT_W       = 128,
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 5
) (
  input  logic       nocclk,
  input  logic       rst_n,
  noc_tx_arbiter_if.slave bus,
  output logic [1:0] grant_owner,
  output logic       locked
);
  typedef enum logic [1:0] {IDLE, LK_WACK, LK_FWD} state_t;
  localparam logic [1:0] SRC_NONE = 2'd0, SRC_ACK = 2'd1, SRC_WACK = 2'd2, SRC_FWD = 2'd3;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  state_t            state_q;
  logic              rr_fwd_q;
  logic [CNT_W-1:0]  wcnt_q, fcnt_q;
  logic [FLIT_W-1:0] out_q;
  logic              out_v_q, locked_q;
  logic [1:0]        owner_q;
  logic              slot_free, w_starve, f_starve, sel_last, wq;
  logic [1:0]        idle_sel, sel;
  logic [FLIT_W-1:0] sel_flit;
  // Starved requesters win first, then ack, then the round-robin pick between wack and fwd.
  assign slot_free = !out_v_q || bus.flit_out_ready;
  assign w_starve  = bus.wack_flit_valid && wcnt_q == LIMIT;
  assign f_starve  = bus.fwd_flit_valid && fcnt_q == LIMIT;
  assign idle_sel  = w_starve ? SRC_WACK : f_starve ? SRC_FWD : bus.ack_flit_valid ? SRC_ACK :
                     (bus.wack_flit_valid && (!rr_fwd_q || !bus.fwd_flit_valid)) ? SRC_WACK :
                     bus.fwd_flit_valid ? SRC_FWD : SRC_NONE;
  assign sel       = !slot_free ? SRC_NONE : state_q == IDLE ? idle_sel :
                     state_q == LK_WACK ? (bus.wack_flit_valid ? SRC_WACK : SRC_NONE) :
                     (bus.fwd_flit_valid ? SRC_FWD : SRC_NONE);
  assign wq        = sel == SRC_WACK || sel == SRC_FWD;
  assign sel_last  = sel == SRC_WACK ? bus.wack_flit_last : bus.fwd_flit_last;
  assign sel_flit  = sel == SRC_ACK ? bus.ack_flit : sel == SRC_WACK ? bus.wack_flit : bus.fwd_flit;
  assign bus.ack_flit_ready  = sel == SRC_ACK;
  assign bus.wack_flit_ready = sel == SRC_WACK;
  assign bus.fwd_flit_ready  = sel == SRC_FWD;
  assign bus.flit_out        = out_q;
  assign bus.flit_out_valid  = out_v_q;
  assign grant_owner         = owner_q;
  assign locked              = locked_q;
  // Output stage, packet lock FSM, round-robin pointer and starvation counters.
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_fwd_q <= 1'b0;
      wcnt_q   <= '0;
      fcnt_q   <= '0;
      out_q    <= '0;
      out_v_q  <= 1'b0;
      owner_q  <= SRC_NONE;
      locked_q <= 1'b0;
    end else begin
      if (sel != SRC_NONE) begin
        out_q   <= sel_flit;
        out_v_q <= 1'b1;
        owner_q <= sel;
      end else if (bus.flit_out_ready) begin
        out_v_q <= 1'b0;
      end
      if (wq && sel_last) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
        rr_fwd_q <= sel == SRC_WACK;
      end else if (wq && state_q == IDLE) begin
        state_q  <= sel == SRC_WACK ? LK_WACK : LK_FWD;
        locked_q <= 1'b1;
      end
      wcnt_q <= sel == SRC_WACK ? '0 : (bus.wack_flit_valid && wcnt_q != LIMIT) ? wcnt_q + CNT_W'(1) : wcnt_q;
      fcnt_q <= sel == SRC_FWD ? '0 : (bus.fwd_flit_valid && fcnt_q != LIMIT) ? fcnt_q + CNT_W'(1) : fcnt_q;
    end
  end
endmodule
